// File: rtl/imm_narrow_seq.sv
// Narrows a constant into one sign-extended SHORT immediate or a HI/LO pair
// of immediate fields, with valid/ready handshakes on both sides.
module imm_narrow_seq #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [1:0]       out_kind,
   output logic             out_last,
   output logic [CNT_W-1:0] cnt_short,
   output logic [CNT_W-1:0] cnt_long
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      EMIT_SHORT = 2'd1,
      EMIT_HI    = 2'd2,
      EMIT_LO    = 2'd3
   } state_t;

   localparam logic [1:0] KIND_SHORT = 2'b00;
   localparam logic [1:0] KIND_HI    = 2'b01;
   localparam logic [1:0] KIND_LO    = 2'b10;

   state_t           state_q, state_d;
   logic [IN_W-1:0]  hold_q, hold_d;
   logic [CNT_W-1:0] cnt_short_q, cnt_short_d;
   logic [CNT_W-1:0] cnt_long_q, cnt_long_d;
   logic             accept;
   logic             xfer;

   // A constant fits when every bit from the top down to the immediate's
   // sign bit is identical, i.e. sign extension of the low field recreates it.
   function automatic logic fits_short(input logic [IN_W-1:0] v);
      logic [IN_W-OUT_W:0] top;
      top = v[IN_W-1:OUT_W-1];
      return (&top) || !(|top);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_imm   = '0;
      out_kind  = KIND_SHORT;
      out_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         EMIT_SHORT: begin
            out_valid = 1'b1;
            out_imm   = hold_q[OUT_W-1:0];
            out_kind  = KIND_SHORT;
            out_last  = 1'b1;
         end
         EMIT_HI: begin
            out_valid = 1'b1;
            out_imm   = hold_q[IN_W-1:OUT_W];
            out_kind  = KIND_HI;
            out_last  = 1'b0;
         end
         EMIT_LO: begin
            out_valid = 1'b1;
            out_imm   = hold_q[OUT_W-1:0];
            out_kind  = KIND_LO;
            out_last  = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign accept = in_valid && in_ready;
   assign xfer   = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      cnt_short_d = cnt_short_q;
      cnt_long_d  = cnt_long_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               hold_d  = in_value;
               state_d = fits_short(in_value) ? EMIT_SHORT : EMIT_HI;
            end
         end
         EMIT_SHORT: begin
            if (xfer) begin
               state_d     = IDLE;
               cnt_short_d = sat_inc(cnt_short_q);
            end
         end
         EMIT_HI: begin
            if (xfer) begin
               state_d = EMIT_LO;
            end
         end
         EMIT_LO: begin
            if (xfer) begin
               state_d    = IDLE;
               cnt_long_d = sat_inc(cnt_long_q);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         cnt_short_q <= '0;
         cnt_long_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         cnt_short_q <= cnt_short_d;
         cnt_long_q  <= cnt_long_d;
      end
   end

   assign cnt_short = cnt_short_q;
   assign cnt_long  = cnt_long_q;

endmodule

// File: tb/tb_imm_narrow_seq.sv
// Scoreboard bench for imm_narrow_seq: stimulus pushes expected chunks, a
// negedge monitor pops and checks each chunk as it is handed off.
module tb_imm_narrow_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_imm;
   logic [1:0]  out_kind;
   logic        out_last;
   logic [15:0] cnt_short;
   logic [15:0] cnt_long;

   typedef struct packed {
      logic [7:0] imm;
      logic [1:0] kind;
      logic       last;
   } chunk_t;

   chunk_t      sb[$];
   logic [15:0] val_q[$];
   logic [7:0]  hi_seen;
   int          vectors = 0;
   int          miscompares = 0;
   bit          rand_rdy = 0;
   int          exp_short = 0;
   int          exp_long = 0;

   always #5 clk = ~clk;

   imm_narrow_seq #(.IN_W(16), .OUT_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_kind(out_kind), .out_last(out_last),
      .cnt_short(cnt_short), .cnt_long(cnt_long)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [7:0] imm, input logic [1:0] kind, input logic last);
      chunk_t c;
      c.imm = imm; c.kind = kind; c.last = last;
      sb.push_back(c);
   endtask

   task automatic send(input logic [15:0] v);
      bit done = 0;
      in_valid = 1'b1;
      in_value = v;
      val_q.push_back(v);
      for (int i = 0; i < 50 && !done; i++) begin
         if (in_ready) done = 1;
         tick();
      end
      in_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
      val_q.delete();
      exp_short = 0;
      exp_long = 0;
   endtask

   // Monitor: a handshake seen at negedge completes at the next posedge.
   initial begin
      chunk_t      e;
      logic [15:0] v;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_chunk", {22'd0, out_imm, out_kind}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("chunk_imm", out_imm, e.imm);
               chk("chunk_kind", out_kind, e.kind);
               chk("chunk_last", out_last, e.last);
            end
            if (out_kind == 2'b01) begin
               hi_seen = out_imm;
            end else if (val_q.size() != 0) begin
               v = val_q.pop_front();
               if (out_kind == 2'b00) chk("short_recon", {{8{out_imm[7]}}, out_imm}, v);
               else                   chk("long_recon", {hi_seen, out_imm}, v);
            end
         end
      end
   end

   initial begin
      logic [15:0] v;
      int          sv;
      rst = 1'b1;
      in_valid = 1'b0;
      in_value = '0;
      out_ready = 1'b0;
      hi_seen = '0;
      do_reset();

      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_out_kind", out_kind, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_cnt_short", cnt_short, 0);
      chk("rst_cnt_long", cnt_long, 0);

      // Single SHORT with one-cycle latency
      out_ready = 1'b1;
      push(8'h0B, 2'b00, 1'b1);
      send(16'h000B);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_in_ready", in_ready, 0);
      tick();
      chk("t1_in_ready", in_ready, 1);
      chk("t1_cnt_short", cnt_short, 1);

      do_reset();
      out_ready = 1'b1;
      push(8'h94, 2'b00, 1'b1);
      send(16'hFF94);
      push(8'h72, 2'b00, 1'b1);
      send(16'h0072);
      drain();
      chk("t2_cnt_short", cnt_short, 2);
      chk("t2_cnt_long", cnt_long, 0);

      // Boundaries around the sign bit of the immediate
      push(8'h00, 2'b01, 1'b0);
      push(8'h80, 2'b10, 1'b1);
      send(16'h0080);
      drain();
      chk("t3_cnt_long", cnt_long, 1);
      push(8'hFF, 2'b01, 1'b0);
      push(8'h7F, 2'b10, 1'b1);
      send(16'hFF7F);
      push(8'h80, 2'b00, 1'b1);
      send(16'hFF80);
      push(8'h7F, 2'b00, 1'b1);
      send(16'h007F);
      drain();
      chk("t3_cnt_long2", cnt_long, 2);
      chk("t3_cnt_short", cnt_short, 4);

      // Backpressure on HI with ignored in_valid pulses
      out_ready = 1'b0;
      push(8'h12, 2'b01, 1'b0);
      push(8'h34, 2'b10, 1'b1);
      send(16'h1234);
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_imm", out_imm, 8'h12);
         chk("bp_kind", out_kind, 2'b01);
         chk("bp_last", out_last, 0);
         chk("bp_in_ready", in_ready, 0);
         in_valid = (i % 2 == 0);
         in_value = 16'h0001;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_lo_imm", out_imm, 8'h34);
      chk("bp_lo_kind", out_kind, 2'b10);
      chk("bp_lo_last", out_last, 1);
      drain();
      chk("bp_cnt_long", cnt_long, 3);
      chk("bp_cnt_short", cnt_short, 4);

      // Reset while HI of a long constant is pending
      out_ready = 1'b0;
      send(16'hABCD);
      chk("mr_kind_hi", out_kind, 2'b01);
      rst = 1'b1;
      tick();
      chk("mr_out_valid", out_valid, 0);
      chk("mr_in_ready", in_ready, 1);
      chk("mr_out_imm", out_imm, 0);
      chk("mr_cnt_short", cnt_short, 0);
      chk("mr_cnt_long", cnt_long, 0);
      rst = 1'b0;
      sb.delete();
      val_q.delete();
      out_ready = 1'b1;
      push(8'h05, 2'b00, 1'b1);
      send(16'h0005);
      drain();
      chk("mr_after_short", cnt_short, 1);

      // Random constants with random consumer backpressure
      do_reset();
      rand_rdy = 1;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 1) == 1) v = 16'($signed($urandom_range(0, 255)) - 128);
         else                           v = 16'($urandom);
         sv = int'($signed(v));
         if (sv >= -128 && sv <= 127) begin
            push(v[7:0], 2'b00, 1'b1);
            exp_short++;
         end else begin
            push(v[15:8], 2'b01, 1'b0);
            push(v[7:0], 2'b10, 1'b1);
            exp_long++;
         end
         send(v);
      end
      rand_rdy = 0;
      out_ready = 1'b1;
      drain();
      chk("rnd_cnt_short", cnt_short, exp_short);
      chk("rnd_cnt_long", cnt_long, exp_long);
      chk("rnd_cnt_total", cnt_short + cnt_long, 1000);
      chk("rnd_idle", in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
